// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-stage data-port responder. Accepts one outstanding
//               request, holds the pipeline with stall while it drives a
//               synchronous single-port SRAM, waits WAIT_CYCLES cycles and
//               returns the raw 32-bit read word on mem_read.
//               Optional malformed-request flag enabled by the macro
//               DMEM_ERR_CHECK_EN (err tied low when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic [3:0]  sel,
  input  logic [1:0]  size,
  output logic [31:0] mem_read,
  output logic        stall,
  output logic        err,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter reload: the WAIT state spans WAIT_CYCLES cycles, last one at zero.
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic        r_req_write;
  logic [29:0] r_req_word;
  logic [31:0] r_req_writedata;
  logic [3:0]  r_req_sel;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem_read;

  // The byte offset is meaningless to a word-wide SRAM; lane selection is in sel.
  logic w_unused_addr;
  assign w_unused_addr = ^addr[1:0];

  // Request FSM: latch in IDLE, issue once, count down, capture, release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= IDLE;
      r_req_write     <= 1'b0;
      r_req_word      <= 30'd0;
      r_req_writedata <= 32'd0;
      r_req_sel       <= 4'd0;
      r_cnt           <= 4'd0;
      r_mem_read      <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_req_write     <= write;
            r_req_word      <= addr[31:2];
            r_req_writedata <= writedata;
            r_req_sel       <= sel;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= c_wait_load;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            if (!r_req_write) begin
              r_mem_read <= ram_rdata;
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          // A still-high en is deliberately ignored here; IDLE samples it next.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Hold the pipeline from the first sight of en until the DONE cycle.
  always_comb begin
    stall = 1'b1;
    case (r_state)
      IDLE:    stall = en;
      DONE:    stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  assign mem_read  = r_mem_read;
  assign ram_en    = (r_state == ISSUE);
  assign ram_wen   = (r_state == ISSUE && r_req_write) ? r_req_sel : 4'b0000;
  assign ram_addr  = {r_req_word, 2'b00};
  assign ram_wdata = r_req_writedata;

`ifdef DMEM_ERR_CHECK_EN
  logic [1:0] r_req_size;
  logic       r_err;
  logic       w_malformed;

  // Size is only needed by the checker, so it is latched alongside it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_req_size <= 2'b00;
    end else if (r_state == IDLE && en) begin
      r_req_size <= size;
    end
  end

  // Classify the latched size/lane combination; loads may use wider lanes.
  always_comb begin
    w_malformed = 1'b0;
    case (r_req_size)
      2'b10:   w_malformed = (r_req_sel != 4'b1111);
      2'b01:   w_malformed = r_req_write && (r_req_sel != 4'b0011) && (r_req_sel != 4'b1100);
      2'b00:   w_malformed = r_req_write && !$onehot(r_req_sel);
      default: w_malformed = 1'b1;
    endcase
  end

  // Raise err for the single DONE cycle that follows the final WAIT cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == WAIT) && (r_cnt == 4'd0) && w_malformed;
    end
  end

  assign err = r_err;
`else
  logic w_unused_size;
  assign w_unused_size = ^size;
  assign err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the CPU's memory-stage data port. Accepts a single outstanding request (`en`, `write`, `addr`, `writedata`, `sel`, `size`) and holds the pipeline via `stall` while the access runs. It drives a synchronous single-port data SRAM with a configurable number of wait cycles, then returns the raw 32-bit read word on `mem_read`. Byte and halfword extraction and alignment exceptions stay in the memory stage.

## Interface
- `WAIT_CYCLES`, 1: cycles from SRAM issue to read-data capture; legal range 1..15.
- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `en`  in  1  request valid; already gated by the memory stage's exception logic.
- `write`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address.
- `writedata`  in  32  store data, already lane-replicated.
- `sel`  in  4  byte lane enables.
- `size`  in  2  access size: 00 = byte, 01 = half, 10 = word.
- `mem_read`  out  32  raw read word, unextracted.
- `stall`  out  1  pipeline hold request.
- `err`  out  1  malformed-request flag (see Configuration).
- `ram_en`  out  1  SRAM enable.
- `ram_wen`  out  4  SRAM per-byte write enables.
- `ram_addr`  out  32  word-aligned SRAM address.
- `ram_wdata`  out  32  SRAM write data.
- `ram_rdata`  in  32  SRAM read data, valid one cycle after `ram_en`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and DONE.
- **IDLE**
  - If `en`=0: `stall`=0 and the state stays IDLE.
  - If `en`=1: `stall`=1 combinationally in the same cycle.
  - Latch `write`, `addr`, `writedata`, `sel` and `size` into request registers, then go to ISSUE.
- **ISSUE**
  - `ram_en`=1 and `stall`=1.
  - `ram_addr`={req_addr[31:2],2'b00}.
  - `ram_wdata`=req_writedata.
  - `ram_wen`=req_write ? req_sel : 4'b0000.
  - Load the wait counter with `WAIT_CYCLES`-1, then go to WAIT.
- **WAIT**
  - `stall`=1; the counter decrements each cycle.
  - When the counter is 0: if req_write=0, capture `ram_rdata` into the `mem_read` register. Then go to DONE.
- **DONE**
  - `stall`=0 for exactly one cycle, so the pipeline advances at the end of this cycle. Go to IDLE unconditionally.
  - `en` still high in DONE does not start a new access. The next request is sampled in the following IDLE cycle.
- **Outside ISSUE:** `ram_en`=0 and `ram_wen`=0000.
- **`mem_read`:** holds its value until the next completed load. Stores leave it unchanged.
- **Store with `sel`=0000:** the access completes normally with no byte written.
- **Inputs during a request:** `en` and the request inputs are ignored in ISSUE, WAIT and DONE. The latched copy is authoritative.

## Timing
- **Reset values:** state = IDLE, `stall`=0 (while `en`=0), `mem_read`=0, `err`=0, `ram_en`=0, `ram_wen`=0, `ram_addr`=0, `ram_wdata`=0.
- **Request latency:** a request first seen in cycle 0 has ISSUE in cycle 1 and WAIT in cycles 2..1+`WAIT_CYCLES`. DONE is in cycle 2+`WAIT_CYCLES`, with `stall` low in that cycle only.
- **Read data:** valid on `mem_read` from the DONE cycle onward.
- **Throughput:** back-to-back requests cost 3+`WAIT_CYCLES` cycles each (DONE→IDLE→ISSUE).
- **Reset mid-operation:** an asynchronous `resetn` assertion in any state forces all reset values immediately. An in-flight store may or may not have reached the SRAM; no completion is signalled.

## Configuration
- **`DMEM_ERR_CHECK_EN` defined:** in DONE, `err`=1 for one cycle when the latched request is malformed. It is malformed if any of these holds:
  - `size`=11;
  - `size`=10 and `sel`≠1111;
  - a store with `size`=01 and `sel`∉{0011,1100};
  - a store with `size`=00 whose `sel` is not one-hot.
- **`DMEM_ERR_CHECK_EN` defined, otherwise:** `err`=0. The access proceeds regardless of `err`.
- **`DMEM_ERR_CHECK_EN` undefined:** `err` is tied to 0 and the check logic is absent.

## Test plan
- **Word load, `WAIT_CYCLES`=1:**
  - Stimulus: `en`=1, `write`=0, `addr`=0x00000104, `sel`=1111, SRAM word 0x104 = 0xDEADBEEF.
  - Required: `stall` high in cycles 0–2 and low in cycle 3; `ram_en` pulse in cycle 1 with `ram_addr`=0x104; `mem_read`=0xDEADBEEF in cycle 3.
- **Byte store:**
  - Stimulus: `addr`=0x00000202, `sel`=0100, `writedata`=0x5A5A5A5A.
  - Required: `ram_wen`=0100 for one cycle; only byte 2 of word 0x200 becomes 0x5A; `mem_read` unchanged.
- **`WAIT_CYCLES`=4 load:** `stall` high for 6 cycles, low in cycle 6; SRAM data changed after the capture cycle does not affect `mem_read`.
- **Held `en` (two back-to-back loads):** `en` held high through DONE with the same address → exactly one `ram_en` pulse per request and 4 cycles per request.
- **Reset mid-operation:** `resetn` asserted during WAIT → `stall`, `ram_en`, `mem_read` and state are zero/IDLE immediately; after release with `en`=0, `stall` stays low.
- **`DMEM_ERR_CHECK_EN` defined:**
  - Word store with `sel`=0011 → `err`=1 in DONE only, and the write is still performed.
  - A legal halfword store at `addr`=0x...2 with `sel`=1100 → `err`=0.
